// File: rtl/rv_word_serializer_if.sv
// Ready/valid bundle between the word source, the serializer and the byte sink.
// Signal names carry the serializer's point of view (_I into it, _O out of it).
interface rv_word_serializer_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic                  WORD_VALID_I;
    logic                  WORD_READY_O;
    logic [WORD_WIDTH-1:0] WORD_DATA_I;
    logic                  BYTE_VALID_O;
    logic                  BYTE_READY_I;
    logic [BYTE_WIDTH-1:0] BYTE_DATA_O;
    logic                  BYTE_LAST_O;
    logic                  ABORT_I;
    logic                  BUSY_O;

    modport slave (
        input  WORD_VALID_I, WORD_DATA_I, BYTE_READY_I, ABORT_I,
        output WORD_READY_O, BYTE_VALID_O, BYTE_DATA_O, BYTE_LAST_O, BUSY_O
    );

    modport master (
        output WORD_VALID_I, WORD_DATA_I, BYTE_READY_I, ABORT_I,
        input  WORD_READY_O, BYTE_VALID_O, BYTE_DATA_O, BYTE_LAST_O, BUSY_O
    );
endinterface

// File: rtl/rv_word_serializer.sv
// Word-to-byte ready/valid serializer, LSB first, with last-beat flag and abort.
// Outputs decode registered state only; RST_I forces them low while asserted.
module rv_word_serializer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    rv_word_serializer_if.slave     bus
);
    localparam int unsigned NUM_BYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

    generate
        if ((WORD_WIDTH % BYTE_WIDTH) != 0 || WORD_WIDTH < BYTE_WIDTH) begin : g_bad_width
            $error("rv_word_serializer: WORD_WIDTH must be a non-zero multiple of BYTE_WIDTH");
        end
    endgenerate

    typedef enum logic {st_idle, st_send} state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;

    logic                  word_ready_c;
    logic                  byte_valid_c;
    logic                  byte_last_c;
    logic                  busy_c;
    logic [BYTE_WIDTH-1:0] byte_data_c;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= st_idle;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    // Next state and output decode; a beat taken together with an abort still counts as sent.
    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        cnt_nxt      = cnt;
        word_ready_c = 1'b0;
        byte_valid_c = 1'b0;
        byte_last_c  = 1'b0;
        busy_c       = 1'b0;
        byte_data_c  = '0;

        case (state)
            st_idle: begin
                word_ready_c = 1'b1;
                if (bus.WORD_VALID_I) begin
                    sreg_nxt  = bus.WORD_DATA_I;
                    cnt_nxt   = '0;
                    state_nxt = st_send;
                end
            end
            st_send: begin
                byte_valid_c = 1'b1;
                busy_c       = 1'b1;
                byte_data_c  = sreg[BYTE_WIDTH-1:0];
                byte_last_c  = (cnt == CNT_LAST);
                if (bus.ABORT_I) begin
                    state_nxt = st_idle;
                end else if (bus.BYTE_READY_I) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = st_idle;
                    end else begin
                        sreg_nxt = sreg >> BYTE_WIDTH;
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    assign bus.WORD_READY_O = word_ready_c & ~RST_I;
    assign bus.BYTE_VALID_O = byte_valid_c & ~RST_I;
    assign bus.BYTE_LAST_O  = byte_last_c  & ~RST_I;
    assign bus.BUSY_O       = busy_c       & ~RST_I;
    assign bus.BYTE_DATA_O  = RST_I ? '0 : byte_data_c;
endmodule

// File: tb/tb_rv_word_serializer.sv
// Directed bench for rv_word_serializer: 32/8 instance plus an 8/8 single-beat instance.
module tb_rv_word_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_word_serializer_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) ia ();
    rv_word_serializer_if #(.WORD_WIDTH(8),  .BYTE_WIDTH(8)) ib ();

    rv_word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) u_dut_a (.CLK_I(clk), .RST_I(rst), .bus(ia));
    rv_word_serializer #(.WORD_WIDTH(8),  .BYTE_WIDTH(8)) u_dut_b (.CLK_I(clk), .RST_I(rst), .bus(ib));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, 32'(ia.BYTE_VALID_O), 32'd1);
        chk({tag, "_data"},  32'(ia.BYTE_DATA_O),  32'(d));
        chk({tag, "_last"},  32'(ia.BYTE_LAST_O),  32'(l));
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_wready"}, 32'(ia.WORD_READY_O), 32'd0);
        chk({tag, "_bvalid"}, 32'(ia.BYTE_VALID_O), 32'd0);
        chk({tag, "_blast"},  32'(ia.BYTE_LAST_O),  32'd0);
        chk({tag, "_busy"},   32'(ia.BUSY_O),       32'd0);
        chk({tag, "_bdata"},  32'(ia.BYTE_DATA_O),  32'd0);
    endtask

    logic [31:0] word;
    logic [7:0]  got_b [16];
    logic        got_l [16];
    int          acc [4];
    int          nb, nacc, idx;
    logic        pat [7];
    logic        took;

    initial begin
        rst = 1'b1;
        ia.WORD_VALID_I = 1'b0; ia.WORD_DATA_I = '0; ia.BYTE_READY_I = 1'b0; ia.ABORT_I = 1'b0;
        ib.WORD_VALID_I = 1'b0; ib.WORD_DATA_I = '0; ib.BYTE_READY_I = 1'b0; ib.ABORT_I = 1'b0;

        // Reset state
        cyc(); cyc();
        all_zero("rst");
        chk("rst_b_wready", 32'(ib.WORD_READY_O), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_wready", 32'(ia.WORD_READY_O), 32'd1);
        chk("post_rst_bvalid", 32'(ia.BYTE_VALID_O), 32'd0);
        chk("post_rst_busy",   32'(ia.BUSY_O),       32'd0);

        // Basic word
        ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = 32'hA1B2C3D4; ia.BYTE_READY_I = 1'b1;
        cyc();
        ia.WORD_VALID_I = 1'b0;
        chk("basic_wready_busy", 32'(ia.WORD_READY_O), 32'd0);
        chk("basic_busy", 32'(ia.BUSY_O), 32'd1);
        beat("basic0", 8'hD4, 1'b0); cyc();
        beat("basic1", 8'hC3, 1'b0); cyc();
        beat("basic2", 8'hB2, 1'b0); cyc();
        beat("basic3", 8'hA1, 1'b1); cyc();
        chk("basic_done_wready", 32'(ia.WORD_READY_O), 32'd1);
        chk("basic_done_bvalid", 32'(ia.BYTE_VALID_O), 32'd0);

        // Backpressure: expected beats D4,C3,C3,C3,B2,B2,A1
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        word = 32'hA1B2C3D4;
        ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = word;
        cyc();
        ia.WORD_VALID_I = 1'b0;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            ia.BYTE_READY_I = pat[i];
            beat($sformatf("bp%0d", i), 8'(word >> (8 * idx)), (idx == 3));
            cyc();
            if (pat[i]) idx++;
        end
        chk("bp_done_wready", 32'(ia.WORD_READY_O), 32'd1);
        chk("bp_done_bvalid", 32'(ia.BYTE_VALID_O), 32'd0);

        // Back-to-back words with WORD_VALID_I held
        ia.BYTE_READY_I = 1'b1; ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = 32'h03020100;
        nb = 0; nacc = 0;
        for (int t = 0; t < 14; t++) begin
            took = ia.WORD_READY_O && ia.WORD_VALID_I;
            if (took && nacc < 4) begin acc[nacc] = t; nacc++; end
            if (ia.BYTE_VALID_O && nb < 16) begin
                got_b[nb] = ia.BYTE_DATA_O; got_l[nb] = ia.BYTE_LAST_O; nb++;
            end
            cyc();
            if (took) begin
                if (nacc == 1) ia.WORD_DATA_I = 32'h07060504;
                else ia.WORD_VALID_I = 1'b0;
            end
        end
        chk("b2b_nbytes", 32'(nb), 32'd8);
        chk("b2b_naccepts", 32'(nacc), 32'd2);
        if (nacc >= 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd5);
        for (int i = 0; i < 8 && i < nb; i++) begin
            chk($sformatf("b2b_data%0d", i), 32'(got_b[i]), 32'(i));
            chk($sformatf("b2b_last%0d", i), 32'(got_l[i]), 32'((i % 4) == 3));
        end

        // Abort after first beat, with the sink stalled
        ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = 32'h11223344; ia.BYTE_READY_I = 1'b1;
        cyc();
        ia.WORD_VALID_I = 1'b0;
        beat("abt0", 8'h44, 1'b0);
        cyc();
        beat("abt1", 8'h33, 1'b0);
        ia.BYTE_READY_I = 1'b0; ia.ABORT_I = 1'b1;
        cyc();
        ia.ABORT_I = 1'b0;
        chk("abt_bvalid", 32'(ia.BYTE_VALID_O), 32'd0);
        chk("abt_wready", 32'(ia.WORD_READY_O), 32'd1);
        chk("abt_busy",   32'(ia.BUSY_O),       32'd0);
        ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = 32'h55667788;
        cyc();
        ia.WORD_VALID_I = 1'b0;
        beat("abt_next0", 8'h88, 1'b0);
        ia.BYTE_READY_I = 1'b1;
        cyc(); beat("abt_next1", 8'h77, 1'b0);
        cyc(); beat("abt_next2", 8'h66, 1'b0);
        cyc(); beat("abt_next3", 8'h55, 1'b1);
        cyc();

        // Abort in idle is ignored; abort with a coincident transfer ends the word
        ia.ABORT_I = 1'b1; ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = 32'hDEADBEEF;
        cyc();
        ia.WORD_VALID_I = 1'b0;
        chk("idle_abt_busy", 32'(ia.BUSY_O), 32'd1);
        beat("idle_abt0", 8'hEF, 1'b0);
        cyc();
        ia.ABORT_I = 1'b0;
        chk("abt_xfer_bvalid", 32'(ia.BYTE_VALID_O), 32'd0);
        chk("abt_xfer_wready", 32'(ia.WORD_READY_O), 32'd1);

        // Reset mid-word
        ia.WORD_VALID_I = 1'b1; ia.WORD_DATA_I = 32'h11223344; ia.BYTE_READY_I = 1'b1;
        cyc();
        ia.WORD_VALID_I = 1'b0;
        beat("mrst0", 8'h44, 1'b0);
        cyc();
        rst = 1'b1;
        #1;
        all_zero("mrst_force");
        cyc();
        all_zero("mrst_c1");
        cyc();
        all_zero("mrst_c2");
        rst = 1'b0;
        cyc();
        chk("mrst_rel_wready", 32'(ia.WORD_READY_O), 32'd1);
        chk("mrst_rel_bvalid", 32'(ia.BYTE_VALID_O), 32'd0);
        nb = 0;
        for (int t = 0; t < 4; t++) begin
            if (ia.BYTE_VALID_O) nb++;
            cyc();
        end
        chk("mrst_no_stale", 32'(nb), 32'd0);

        // Single-beat instance: 2-cycle spacing, LAST on every beat
        ib.BYTE_READY_I = 1'b1; ib.WORD_VALID_I = 1'b1; ib.WORD_DATA_I = 8'h5A;
        nb = 0; nacc = 0;
        for (int t = 0; t < 6; t++) begin
            took = ib.WORD_READY_O && ib.WORD_VALID_I;
            if (took && nacc < 4) begin acc[nacc] = t; nacc++; end
            if (ib.BYTE_VALID_O && nb < 16) begin
                got_b[nb] = ib.BYTE_DATA_O; got_l[nb] = ib.BYTE_LAST_O; nb++;
            end
            cyc();
            if (took) begin
                if (nacc == 1) ib.WORD_DATA_I = 8'hA5;
                else ib.WORD_VALID_I = 1'b0;
            end
        end
        chk("n1_nbytes", 32'(nb), 32'd2);
        chk("n1_naccepts", 32'(nacc), 32'd2);
        if (nacc >= 2) chk("n1_spacing", 32'(acc[1] - acc[0]), 32'd2);
        if (nb >= 2) begin
            chk("n1_data0", 32'(got_b[0]), 32'h5A);
            chk("n1_last0", 32'(got_l[0]), 32'd1);
            chk("n1_data1", 32'(got_b[1]), 32'hA5);
            chk("n1_last1", 32'(got_l[1]), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv_word_serializer.md
# rv_word_serializer

Ready/valid word-to-byte serializer between the read side of the trace buffer's ready/valid register stage and the byte-wide UART transmitter. It accepts one WORD_WIDTH word and emits it as NUM_BYTES consecutive BYTE_WIDTH beats, least significant byte first, over a ready/valid byte stream. It marks the final beat of each word and supports a synchronous abort.

## Interface
- WORD_WIDTH, 32: input word width. Must be an integer multiple of BYTE_WIDTH and at least BYTE_WIDTH.
- BYTE_WIDTH, 8: output beat width.
- NUM_BYTES (localparam): WORD_WIDTH/BYTE_WIDTH. The beat counter is $clog2(NUM_BYTES) bits, minimum 1.

Ports:
- CLK_I  in  1  sole clock; everything is on the rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- WORD_VALID_I  in  1  upstream word valid.
- WORD_READY_O  out  1  block can accept a word.
- WORD_DATA_I  in  WORD_WIDTH  upstream word.
- BYTE_VALID_O  out  1  output beat valid.
- BYTE_READY_I  in  1  downstream (UART TX) ready.
- BYTE_DATA_O  out  BYTE_WIDTH  output beat.
- BYTE_LAST_O  out  1  current beat is the word's final byte.
- ABORT_I  in  1  drops the remaining bytes of the current word.
- BUSY_O  out  1  a word is held (state is st_send).

## Operation
- Storage:
  - shift register sreg (WORD_WIDTH bits).
  - beat counter cnt.
  - state: st_idle or st_send.
- Handshake rules:
  - A word transfer occurs when WORD_VALID_I && WORD_READY_O.
  - A byte transfer occurs when BYTE_VALID_O && BYTE_READY_I.
- st_idle:
  - WORD_READY_O=1, BYTE_VALID_O=0, BUSY_O=0.
  - On a word transfer: sreg<=WORD_DATA_I, cnt<=0, go to st_send.
- st_send:
  - WORD_READY_O=0, BYTE_VALID_O=1, BUSY_O=1.
  - BYTE_DATA_O=sreg[BYTE_WIDTH-1:0]; BYTE_LAST_O=(cnt==NUM_BYTES-1).
  - On a byte transfer with cnt<NUM_BYTES-1: sreg shifts right by BYTE_WIDTH (zero fill) and cnt increments.
  - On a byte transfer with cnt==NUM_BYTES-1: go to st_idle.
  - With no byte transfer, BYTE_DATA_O and BYTE_LAST_O hold stable. BYTE_VALID_O never deasserts before acceptance, except on abort or reset.
- ABORT_I:
  - In st_send: go to st_idle next cycle and drop the remaining bytes.
  - If a byte transfer coincides with the abort, that byte counts as delivered.
  - In st_idle ABORT_I has no effect, and a word offered in that cycle is still accepted.
- NUM_BYTES==1: every beat has BYTE_LAST_O=1, and the block behaves as a one-deep register slice with a bubble.
- Width rule: WORD_WIDTH not a multiple of BYTE_WIDTH is a parameter error and must fail elaboration ($error in a generate check).

## Timing
- Reset:
  - While RST_I is high: state<=st_idle, cnt<=0, sreg<=0.
  - While RST_I is high, the outputs are forced low: WORD_READY_O=0, BYTE_VALID_O=0, BYTE_LAST_O=0, BUSY_O=0, BYTE_DATA_O=0.
  - First cycle after RST_I falls: WORD_READY_O=1.
- Reset mid-word: the word is discarded. BYTE_VALID_O is 0 in the cycle RST_I is sampled high and stays 0 afterwards until a new word is accepted.
- Latency: word accepted at edge n gives byte 0 valid in cycle n+1 (after that edge).
- Throughput:
  - With BYTE_READY_I held high, a word takes NUM_BYTES cycles in st_send plus 1 cycle in st_idle.
  - Minimum spacing between word acceptances is NUM_BYTES+1 cycles.
  - WORD_READY_O is registered-state-only and has no combinational path from BYTE_READY_I.
- Combinational paths:
  - All outputs are decoded from registered state and sreg/cnt only.
  - There are no input-to-output combinational paths other than the reset forcing.
- Backpressure: BYTE_READY_I low stalls indefinitely with no data loss.

## Test plan
- Basic word: WORD_WIDTH=32, accept 0xA1B2C3D4 with BYTE_READY_I=1 -> beats 0xD4, 0xC3, 0xB2, 0xA1 on four consecutive cycles, BYTE_LAST_O only on 0xA1, WORD_READY_O=1 on the following cycle.
- Backpressure: same word, BYTE_READY_I toggling 1,0,0,1,0,1,1 -> same four beats in order, BYTE_DATA_O/BYTE_LAST_O stable during stalls, BYTE_VALID_O never drops mid-word.
- Back-to-back: WORD_VALID_I held high with 0x03020100 then 0x07060504, ready=1 -> beats 00..07 in order, words accepted exactly 5 cycles apart, LAST on 0x03 and 0x07.
- Abort: accept 0x11223344; after beat 0x44 is accepted, pulse ABORT_I with BYTE_READY_I=0 -> next cycle BYTE_VALID_O=0, WORD_READY_O=1; the next word 0x55667788 emits 0x88 first.
- Reset mid-word: after beat 0x44 of 0x11223344, assert RST_I for 2 cycles -> all outputs 0 during reset, WORD_READY_O=1 the first cycle after release, no stale bytes emitted.
- NUM_BYTES=1 (WORD_WIDTH=8): words 0x5A, 0xA5 -> each emitted once with BYTE_LAST_O=1, 2-cycle spacing.
